lcd_refresh_ctrl: RTL and testbench

//  HD44780-compatible 16x2 character-LCD controller.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_write_strobe.sv | 77 +++++++
 rtl/lcd_refresh_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, sequencer and write-phase states,
// and the fixed power-up command table shared by the LCD controller.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_ADDR1,
    S_FETCH,
    S_DATA,
    S_ADDR2,
    S_FRAME,
    S_GAP
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_WAIT
  } wr_phase_t;

  function automatic logic [7:0] init_cmd(
    input logic [1:0] i
  );
    logic [7:0] c;
    unique case (i)
      2'd0: c = LCD_FUNC_SET;
      2'd1: c = LCD_DISP_ON;
      2'd2: c = LCD_ENTRY;
      2'd3: c = LCD_CLEAR;
      default: c = LCD_FUNC_SET;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// lcd_write_strobe: one HD44780 byte write (SETUP, STROBE, WAIT).
// Ports: go/rs/data_byte/long_wait start a write; lcd_rs/en/data
// drive the bus; done pulses in the last WAIT cycle so the next
// write can start on the following edge with no idle cycle.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int EN_P  = 25,
  parameter int CMD_W = 2500,
  parameter int CLR_W = 100000,
  parameter int CW    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       rs,
  input  logic [7:0] data_byte,
  input  logic       long_wait,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam logic [CW-1:0] EN_LD  = CW'(EN_P - 1);
  localparam logic [CW-1:0] CMD_LD = CW'(CMD_W - 1);
  localparam logic [CW-1:0] CLR_LD = CW'(CLR_W - 1);

  wr_phase_t     phase;
  logic [CW-1:0] cnt;
  logic          long_q;

  // bus bytes are latched on go and held until the next go
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (go) begin
      phase    <= PH_SETUP;
      cnt      <= '0;
      long_q   <= long_wait;
      lcd_rs   <= rs;
      lcd_data <= data_byte;
      lcd_en   <= 1'b0;
    end else begin
      unique case (phase)
        PH_SETUP: begin
          phase  <= PH_STROBE;
          lcd_en <= 1'b1;
          cnt    <= EN_LD;
        end
        PH_STROBE: begin
          if (cnt == '0) begin
            phase  <= PH_WAIT;
            lcd_en <= 1'b0;
            cnt    <= long_q ? CLR_LD : CMD_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH_WAIT: begin
          if (cnt == '0) phase <= PH_IDLE;
          else cnt <= cnt - 1'b1;
        end
        PH_IDLE: ;
        default: phase <= PH_IDLE;
      endcase
    end
  end

  assign done = (phase == PH_WAIT) && (cnt == '0);

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: 16x2 HD44780 controller; power-up init once, then
// endless refresh of 32 chars fetched via index/char_in.
// Ports: clk, rst (sync, high), char_in; index, lcd_rs/rw/en/data,
// init_done (sticky), frame_done (1-cycle pulse per frame).
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC  = 750000,
  parameter int EN_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int GAP_CYC      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  // zero-valued timings behave as one cycle
  localparam int PWR_N = (POWERUP_CYC  < 1) ? 1 : POWERUP_CYC;
  localparam int EN_N  = (EN_PULSE_CYC < 1) ? 1 : EN_PULSE_CYC;
  localparam int CMD_N = (CMD_WAIT_CYC < 1) ? 1 : CMD_WAIT_CYC;
  localparam int CLR_N = (CLR_WAIT_CYC < 1) ? 1 : CLR_WAIT_CYC;
  localparam int GAP_N = (GAP_CYC      < 1) ? 1 : GAP_CYC;
  localparam int BIG1  = (PWR_N > CLR_N) ? PWR_N : CLR_N;
  localparam int BIG   = (BIG1 > GAP_N) ? BIG1 : GAP_N;
  localparam int CW    = $clog2(BIG + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_N - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_N - 1);

  lcd_state_t    state;
  logic [CW-1:0] tmr;
  logic [1:0]    rom_idx;
  logic [4:0]    ptr;

  logic       wr_go;
  logic       wr_rs;
  logic [7:0] wr_byte;
  logic       wr_long;
  logic       wr_done;

  assign lcd_rw = 1'b0;

  // next write is issued in the same cycle the previous one
  // signals done, so transfers run back-to-back
  always_comb begin
    wr_go   = 1'b0;
    wr_rs   = 1'b0;
    wr_byte = 8'h00;
    unique case (state)
      S_PWRUP: begin
        if (tmr == PWR_LAST) begin
          wr_go   = 1'b1;
          wr_byte = init_cmd(2'd0);
        end
      end
      S_INIT: begin
        if (wr_done) begin
          wr_go   = 1'b1;
          wr_byte = (rom_idx == 2'd3) ? LCD_LINE1
                  : init_cmd(rom_idx + 2'd1);
        end
      end
      S_FETCH: begin
        wr_go   = 1'b1;
        wr_rs   = 1'b1;
        wr_byte = char_in;
      end
      S_DATA: begin
        if (wr_done && ptr == 5'd15) begin
          wr_go   = 1'b1;
          wr_byte = LCD_LINE2;
        end
      end
      S_FRAME: begin
        if (GAP_CYC == 0) begin
          wr_go   = 1'b1;
          wr_byte = LCD_LINE1;
        end
      end
      S_GAP: begin
        if (tmr == GAP_LAST) begin
          wr_go   = 1'b1;
          wr_byte = LCD_LINE1;
        end
      end
      default: ;
    endcase
  end

  assign wr_long = !wr_rs && (wr_byte == LCD_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PWRUP;
      tmr        <= '0;
      rom_idx    <= 2'd0;
      ptr        <= 5'd0;
      index      <= 5'd0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_PWRUP: begin
          if (tmr == PWR_LAST) begin
            tmr   <= '0;
            state <= S_INIT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_INIT: begin
          if (wr_done) begin
            if (rom_idx == 2'd3) begin
              init_done <= 1'b1;
              state     <= S_ADDR1;
            end else begin
              rom_idx <= rom_idx + 2'd1;
            end
          end
        end
        S_ADDR1, S_ADDR2: begin
          if (wr_done) begin
            index <= ptr;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DATA;
        S_DATA: begin
          if (wr_done) begin
            if (ptr == 5'd15) begin
              ptr   <= 5'd16;
              state <= S_ADDR2;
            end else if (ptr == 5'd31) begin
              ptr        <= 5'd0;
              frame_done <= 1'b1;
              state      <= S_FRAME;
            end else begin
              ptr   <= ptr + 5'd1;
              index <= ptr + 5'd1;
              state <= S_FETCH;
            end
          end
        end
        S_FRAME: begin
          tmr   <= '0;
          state <= (GAP_CYC == 0) ? S_ADDR1 : S_GAP;
        end
        S_GAP: begin
          if (tmr == GAP_LAST) begin
            tmr   <= '0;
            state <= S_ADDR1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

  lcd_write_strobe #(
    .EN_P  (EN_N),
    .CMD_W (CMD_N),
    .CLR_W (CLR_N),
    .CW    (CW)
  ) u_wr (
    .clk       (clk),
    .rst       (rst),
    .go        (wr_go),
    .rs        (wr_rs),
    .data_byte (wr_byte),
    .long_wait (wr_long),
    .lcd_rs    (lcd_rs),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data),
    .done      (wr_done)
  );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl: directed bench for lcd_refresh_ctrl with short
// timings (10/2/4/8/0); a negedge monitor logs every lcd_en rise.
module tb_lcd_refresh_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  logic       init_done, frame_done;

  logic       ovr_en;
  logic [7:0] ovr_val;
  bit         mon_off;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         ev_cyc[$];
  logic [7:0] ev_data[$];
  logic       ev_rs[$];
  logic [4:0] ev_idx[$];
  int         wid[$];
  int         fd_cyc[$];
  int fd_cnt = 0, fd_hi = 0, id_cyc = -1;
  int rw_viol = 0, stab_viol = 0;
  int en_run = 0, hold_left = 0;
  logic en_prev = 1'b0, fd_prev = 1'b0, id_prev = 1'b0;
  logic [7:0] ref_d;
  logic ref_rs;

  lcd_refresh_ctrl #(
    .POWERUP_CYC  (10),
    .EN_PULSE_CYC (2),
    .CMD_WAIT_CYC (4),
    .CLR_WAIT_CYC (8),
    .GAP_CYC      (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .index      (index),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // string-stage model: char = 'A' + index
  assign char_in = ovr_en ? ovr_val : 8'h41 + {3'b000, index};

  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_viol++;
    if (lcd_en && !en_prev) begin
      ev_cyc.push_back(cyc);
      ev_data.push_back(lcd_data);
      ev_rs.push_back(lcd_rs);
      ev_idx.push_back(index);
      ref_d = lcd_data;
      ref_rs = lcd_rs;
      hold_left = 2 + ((lcd_data == 8'h01 && !lcd_rs) ? 8 : 4);
    end
    if (lcd_en) en_run++;
    else if (en_prev) begin
      wid.push_back(en_run);
      en_run = 0;
    end
    if (mon_off) hold_left = 0;
    else if (hold_left > 0) begin
      if (lcd_data !== ref_d || lcd_rs !== ref_rs) stab_viol++;
      hold_left--;
    end
    if (frame_done) fd_hi++;
    if (frame_done && !fd_prev) begin
      fd_cnt++;
      fd_cyc.push_back(cyc);
    end
    if (init_done && !id_prev && id_cyc < 0) id_cyc = cyc;
    en_prev = lcd_en;
    fd_prev = frame_done;
    id_prev = init_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ev(input int n, input int budget,
                         input string tag);
    int t = 0;
    while (ev_cyc.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(ev_cyc.size() >= n), 32'd1);
  endtask

  initial begin
    int rel, base, t, k;
    logic [7:0] exp_d;
    logic exp_rs;
    logic [7:0] init_seq [0:4];
    init_seq[0] = 8'h38;
    init_seq[1] = 8'h0C;
    init_seq[2] = 8'h06;
    init_seq[3] = 8'h01;
    init_seq[4] = 8'h80;

    rst = 1'b1;
    ovr_en = 1'b0;
    ovr_val = 8'h00;
    mon_off = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(lcd_en), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rel = cyc;
    rst = 1'b0;

    // power-up and init
    wait_ev(5, 400, "init_events");
    chk("pwrup_latency", 32'(ev_cyc[0] - rel), 32'd11);
    for (int i = 0; i < 4; i++) begin
      chk("init_byte", 32'(ev_data[i]), 32'(init_seq[i]));
      chk("init_rs", 32'(ev_rs[i]), 32'd0);
      chk("init_en_width", 32'(wid[i]), 32'd2);
    end
    chk("cmd_period", 32'(ev_cyc[1] - ev_cyc[0]), 32'd7);
    chk("clear_gap", 32'(ev_cyc[4] - ev_cyc[3]), 32'd11);
    chk("init_done_rise", 32'(id_cyc - ev_cyc[3]), 32'd10);

    // first frame and start of the second
    wait_ev(39, 600, "frame1_events");
    chk("fd_count_f1", 32'(fd_cnt), 32'd1);
    chk("fd_timing", 32'(fd_cyc[0] - ev_cyc[37]), 32'd6);
    chk("char_period_l1", 32'(ev_cyc[6] - ev_cyc[5]), 32'd8);
    chk("char_period_l2", 32'(ev_cyc[30] - ev_cyc[29]), 32'd8);
    chk("frame_to_addr1", 32'(ev_cyc[38] - ev_cyc[37]), 32'd8);
    chk("frame2_addr1", 32'(ev_data[38]), 32'h80);

    // fetch latency: char_in changes after the sampling edge
    t = 0;
    while (index !== 5'd3 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("reach_idx3", 32'(index), 32'd3);
    @(negedge clk);
    ovr_val = 8'h7E;
    ovr_en = 1'b1;
    @(negedge clk);
    chk("latched_byte_strobe", 32'(lcd_data), 32'h44);
    repeat (3) @(negedge clk);
    chk("latched_byte_wait", 32'(lcd_data), 32'h44);
    ovr_en = 1'b0;

    // three frames end to end
    wait_ev(107, 1500, "three_frames");
    chk("fd_count_3", 32'(fd_cnt), 32'd3);
    chk("fd_high_cycles", 32'(fd_hi), 32'd3);
    for (int j = 4; j < 107; j++) begin
      k = (j - 4) % 34;
      if (k == 0) begin
        exp_d = 8'h80; exp_rs = 1'b0;
      end else if (k <= 16) begin
        exp_d = 8'h41 + 8'(k - 1); exp_rs = 1'b1;
      end else if (k == 17) begin
        exp_d = 8'hC0; exp_rs = 1'b0;
      end else begin
        exp_d = 8'h51 + 8'(k - 18); exp_rs = 1'b1;
      end
      chk("frame_byte", 32'(ev_data[j]), 32'(exp_d));
      chk("frame_rs", 32'(ev_rs[j]), 32'(exp_rs));
    end
    for (int f = 0; f < 3; f++)
      chk("idx_last", 32'(ev_idx[37 + 34 * f]), 32'd31);
    for (int f = 0; f < 2; f++)
      chk("idx_wrap", 32'(ev_idx[39 + 34 * f]), 32'd0);
    chk("rw_low", 32'(rw_viol), 32'd0);
    chk("bus_stable", 32'(stab_viol), 32'd0);

    // reset while strobing char 20
    t = 0;
    while (!(index === 5'd20 && lcd_en === 1'b1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("reach_char20", 32'(index), 32'd20);
    mon_off = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_en", 32'(lcd_en), 32'd0);
    chk("mrst_index", 32'(index), 32'd0);
    chk("mrst_init_done", 32'(init_done), 32'd0);
    base = ev_cyc.size();
    rel = cyc;
    rst = 1'b0;
    @(negedge clk);
    mon_off = 1'b0;
    wait_ev(base + 5, 400, "reinit_events");
    chk("reinit_latency", 32'(ev_cyc[base] - rel), 32'd11);
    for (int i = 0; i < 5; i++) begin
      chk("reinit_byte", 32'(ev_data[base + i]), 32'(init_seq[i]));
      chk("reinit_rs", 32'(ev_rs[base + i]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
